// File: rtl/sram_bus_if.sv
// Processor-side request/response signals plus the SRAM strobe/address pins.
// The controller connects through the slave modport; the requester side uses master.
interface sram_bus_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  req;
   logic                  wr;
   logic [ADDR_WIDTH-1:0] adr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ready;
   logic                  busy;
   logic                  ce_n;
   logic                  oe_n;
   logic                  we_n;
   logic [ADDR_WIDTH-1:0] mem_adr;

   modport slave (
      input  req, wr, adr, wdata,
      output rdata, ready, busy, ce_n, oe_n, we_n, mem_adr
   );

   modport master (
      output req, wr, adr, wdata,
      input  rdata, ready, busy, ce_n, oe_n, we_n, mem_adr
   );
endinterface

// File: rtl/sram_bus_ctrl.sv
// Async SRAM bus controller: SETUP, WAIT_STATES access cycles, HOLD, with registered strobes
// and ownership of the shared data bus tristate drive.
module sram_bus_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                  clk1,
   input  logic                  reset,
   sram_bus_if.slave             bus,
   // Kept as a plain port so the tristate net resolves at the board/bench level.
   inout  wire  [DATA_WIDTH-1:0] mem_data
);

   if (WAIT_STATES == 0) begin : g_bad_wait_states
      $error("sram_bus_ctrl: WAIT_STATES must be >= 1");
   end

   localparam int unsigned CNT_W = $clog2(WAIT_STATES + 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_next;
   logic                  w_accept;
   logic                  w_wr_next;
   logic                  w_rd_done;

   logic                  r_wr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [ADDR_WIDTH-1:0] r_mem_adr;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_ce_n;
   logic                  r_oe_n;
   logic                  r_we_n;
   logic                  r_drive;

   logic                  w_ce_n_next;
   logic                  w_oe_n_next;
   logic                  w_we_n_next;
   logic                  w_drive_next;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      case (r_state)
         StIdle: begin
            if (bus.req) begin
               w_state_next = StSetup;
               w_accept     = 1'b1;
            end
         end
         StSetup: begin
            w_state_next = StAccess;
            w_cnt_next   = CNT_W'(WAIT_STATES);
         end
         StAccess: begin
            if (r_cnt == CNT_W'(1)) begin
               w_state_next = StHold;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end
         StHold: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // Pin values are decoded from the next state so every strobe leaves a flop directly.
   always_comb begin
      w_wr_next    = w_accept ? bus.wr : r_wr;
      w_ce_n_next  = (w_state_next == StIdle);
      w_oe_n_next  = !((w_state_next == StAccess) && !w_wr_next);
      w_we_n_next  = !((w_state_next == StAccess) && w_wr_next);
      w_drive_next = (w_state_next != StIdle) && w_wr_next;
      w_rd_done    = (r_state == StAccess) && (r_cnt == CNT_W'(1)) && !r_wr;
   end

   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_wr      <= 1'b0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_mem_adr <= '0;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_ce_n    <= 1'b1;
         r_oe_n    <= 1'b1;
         r_we_n    <= 1'b1;
         r_drive   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_wr      <= bus.wr;
            r_wdata   <= bus.wdata;
            r_mem_adr <= bus.adr;
         end
         if (w_rd_done) begin
            r_rdata <= mem_data;
         end
         r_ready <= (w_state_next == StHold);
         r_busy  <= (w_state_next != StIdle);
         r_ce_n  <= w_ce_n_next;
         r_oe_n  <= w_oe_n_next;
         r_we_n  <= w_we_n_next;
         r_drive <= w_drive_next;
      end
   end

   assign mem_data    = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
   assign bus.rdata   = r_rdata;
   assign bus.ready   = r_ready;
   assign bus.busy    = r_busy;
   assign bus.ce_n    = r_ce_n;
   assign bus.oe_n    = r_oe_n;
   assign bus.we_n    = r_we_n;
   assign bus.mem_adr = r_mem_adr;

   a_no_oe_we: assert property (@(posedge clk1) disable iff (reset) !(!r_oe_n && !r_we_n));
   a_no_oe_drive: assert property (@(posedge clk1) disable iff (reset) !(!r_oe_n && r_drive));
   a_we_drive: assert property (@(posedge clk1) disable iff (reset) !r_we_n |-> r_drive);
   a_adr_stable: assert property (@(posedge clk1) disable iff (reset)
                                  (r_busy && $past(r_busy)) |-> $stable(r_mem_adr));

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench: a W=1 controller with a behavioural SRAM, and a W=3 controller whose
// SRAM returns {8'h5A, address}.
module tb_sram_bus_ctrl;

   logic clk1 = 1'b0;
   logic rst_a;
   logic rst_b;
   always #5 clk1 = ~clk1;

   sram_bus_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus_a ();
   sram_bus_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus_b ();
   wire [15:0] mem_data_a;
   wire [15:0] mem_data_b;
   pullup (mem_data_a);
   pullup (mem_data_b);

   sram_bus_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(1)) u_dut_a (
      .clk1    (clk1),
      .reset   (rst_a),
      .bus     (bus_a),
      .mem_data(mem_data_a)
   );

   sram_bus_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(3)) u_dut_b (
      .clk1    (clk1),
      .reset   (rst_b),
      .bus     (bus_b),
      .mem_data(mem_data_b)
   );

   logic [15:0] sram [256];
   logic [15:0] sram_q;
   assign sram_q     = sram[bus_a.mem_adr];
   assign mem_data_a = (!bus_a.ce_n && !bus_a.oe_n) ? sram_q : 16'hzzzz;
   always @(posedge clk1) begin
      if (!bus_a.ce_n && !bus_a.we_n) sram[bus_a.mem_adr] <= mem_data_a;
   end
   assign mem_data_b = (!bus_b.ce_n && !bus_b.oe_n) ? {8'h5A, bus_b.mem_adr} : 16'hzzzz;

   int checks = 0;
   int errors = 0;
   int overlap = 0;
   always @(negedge clk1) begin
      if ((!bus_a.oe_n && !bus_a.we_n) || (!bus_b.oe_n && !bus_b.we_n)) overlap++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   typedef struct {
      logic        wr;
      logic [7:0]  adr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t        vecs [8];
   logic [15:0] last_rd;

   // Single-cycle request on instance A, checked cycle by cycle until it is idle again.
   task automatic run_acc(input string nm, input logic wr, input logic [7:0] adr,
                          input logic [15:0] wd, input logic [15:0] exp_rd);
      logic [15:0] bus_c13;
      bus_c13 = wr ? wd : 16'hFFFF;
      bus_a.req = 1'b1; bus_a.wr = wr; bus_a.adr = adr; bus_a.wdata = wd;
      tick();
      bus_a.req = 1'b0;
      chk({nm, " c1 ce_n"}, bus_a.ce_n, 0);
      chk({nm, " c1 oe_n"}, bus_a.oe_n, 1);
      chk({nm, " c1 we_n"}, bus_a.we_n, 1);
      chk({nm, " c1 busy"}, bus_a.busy, 1);
      chk({nm, " c1 mem_adr"}, bus_a.mem_adr, adr);
      chk({nm, " c1 mem_data"}, mem_data_a, bus_c13);
      tick();
      chk({nm, " c2 oe_n"}, bus_a.oe_n, wr);
      chk({nm, " c2 we_n"}, bus_a.we_n, !wr);
      chk({nm, " c2 ready"}, bus_a.ready, 0);
      chk({nm, " c2 mem_data"}, mem_data_a, wr ? wd : exp_rd);
      tick();
      if (!wr) last_rd = exp_rd;
      chk({nm, " c3 ready"}, bus_a.ready, 1);
      chk({nm, " c3 strobes"}, {bus_a.ce_n, bus_a.oe_n, bus_a.we_n}, 3'b011);
      chk({nm, " c3 mem_data"}, mem_data_a, bus_c13);
      chk({nm, " c3 rdata"}, bus_a.rdata, last_rd);
      tick();
      chk({nm, " c4 idle"}, {bus_a.ce_n, bus_a.busy, bus_a.ready}, 3'b100);
      chk({nm, " c4 mem_data"}, mem_data_a, 16'hFFFF);
   endtask

   initial begin
      int ce_cnt;
      int oe_cnt;
      int rdy_cnt;
      int rdy_cyc;
      logic [15:0] rd_at_rdy;

      vecs[0] = '{wr: 1'b1, adr: 8'h20, wdata: 16'h002D, exp_rd: 16'h0000};
      vecs[1] = '{wr: 1'b0, adr: 8'h20, wdata: 16'h0000, exp_rd: 16'h002D};
      vecs[2] = '{wr: 1'b1, adr: 8'h21, wdata: 16'hA5C3, exp_rd: 16'h0000};
      vecs[3] = '{wr: 1'b1, adr: 8'hFF, wdata: 16'h8001, exp_rd: 16'h0000};
      vecs[4] = '{wr: 1'b0, adr: 8'h21, wdata: 16'h0000, exp_rd: 16'hA5C3};
      vecs[5] = '{wr: 1'b0, adr: 8'hFF, wdata: 16'h0000, exp_rd: 16'h8001};
      vecs[6] = '{wr: 1'b1, adr: 8'h00, wdata: 16'h0000, exp_rd: 16'h0000};
      vecs[7] = '{wr: 1'b0, adr: 8'h00, wdata: 16'h0000, exp_rd: 16'h0000};

      bus_a.req = 1'b0; bus_a.wr = 1'b0; bus_a.adr = '0; bus_a.wdata = '0;
      bus_b.req = 1'b0; bus_b.wr = 1'b0; bus_b.adr = '0; bus_b.wdata = '0;
      rst_a = 1'b1; rst_b = 1'b1;
      last_rd = 16'h0000;

      repeat (2) tick();
      chk("rst strobes", {bus_a.ce_n, bus_a.oe_n, bus_a.we_n}, 3'b111);
      chk("rst busy/ready", {bus_a.busy, bus_a.ready}, 2'b00);
      chk("rst rdata", bus_a.rdata, 16'h0000);
      chk("rst mem_adr", bus_a.mem_adr, 8'h00);
      chk("rst mem_data", mem_data_a, 16'hFFFF);
      chk("rst b strobes", {bus_b.ce_n, bus_b.oe_n, bus_b.we_n, bus_b.busy}, 4'b1110);
      rst_a = 1'b0; rst_b = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_acc($sformatf("v%0d", i), vecs[i].wr, vecs[i].adr, vecs[i].wdata, vecs[i].exp_rd);
      end

      // Back-to-back: req held high, write then read of the same address.
      bus_a.req = 1'b1; bus_a.wr = 1'b1; bus_a.adr = 8'h10; bus_a.wdata = 16'hBEEF;
      tick();
      chk("b2b c1 busy", bus_a.busy, 1);
      bus_a.wr = 1'b0;
      tick();
      tick();
      chk("b2b c3 ready", bus_a.ready, 1);
      tick();
      chk("b2b c4 idle", {bus_a.busy, bus_a.ce_n}, 2'b01);
      tick();
      bus_a.req = 1'b0;
      chk("b2b c5 second accept", {bus_a.busy, bus_a.ce_n, bus_a.oe_n}, 3'b101);
      chk("b2b c5 released", mem_data_a, 16'hFFFF);
      tick();
      chk("b2b c6 oe_n", bus_a.oe_n, 0);
      tick();
      chk("b2b c7 ready", bus_a.ready, 1);
      chk("b2b c7 rdata", bus_a.rdata, 16'hBEEF);
      tick();

      // W=3 read with an ignored request pulsed while the access is in progress.
      bus_b.req = 1'b1; bus_b.wr = 1'b0; bus_b.adr = 8'h44;
      tick();
      bus_b.req = 1'b0;
      ce_cnt = 0; oe_cnt = 0; rdy_cnt = 0; rdy_cyc = 0; rd_at_rdy = 16'h0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         if (!bus_b.ce_n) ce_cnt++;
         if (!bus_b.oe_n) oe_cnt++;
         if (bus_b.ready) begin
            rdy_cnt++;
            if (rdy_cyc == 0) begin
               rdy_cyc = cyc;
               rd_at_rdy = bus_b.rdata;
               chk("w3 mem_adr at ready", bus_b.mem_adr, 8'h44);
            end
         end
         if (cyc == 2) begin bus_b.req = 1'b1; bus_b.adr = 8'h33; end
         if (cyc == 3) bus_b.req = 1'b0;
         tick();
      end
      chk("w3 ce_n low cycles", ce_cnt, 5);
      chk("w3 oe_n low cycles", oe_cnt, 3);
      chk("w3 ready cycle", rdy_cyc, 5);
      chk("w3 ready pulses", rdy_cnt, 1);
      chk("w3 rdata", rd_at_rdy, 16'h5A44);

      // Reset asserted in the middle of a write ACCESS cycle.
      bus_a.req = 1'b1; bus_a.wr = 1'b1; bus_a.adr = 8'h30; bus_a.wdata = 16'h1234;
      tick();
      bus_a.req = 1'b0;
      tick();
      chk("rstmid we_n before", bus_a.we_n, 0);
      #2 rst_a = 1'b1;
      #1;
      chk("rstmid strobes", {bus_a.ce_n, bus_a.oe_n, bus_a.we_n}, 3'b111);
      chk("rstmid busy/ready", {bus_a.busy, bus_a.ready}, 2'b00);
      chk("rstmid mem_data", mem_data_a, 16'hFFFF);
      tick();
      rst_a = 1'b0;
      last_rd = 16'h0000;
      rdy_cnt = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         if (bus_a.ready) rdy_cnt++;
         tick();
      end
      chk("rstmid no ready", rdy_cnt, 0);
      run_acc("post-rst wr", 1'b1, 8'h30, 16'h5678, 16'h0000);
      run_acc("post-rst rd", 1'b0, 8'h30, 16'h0000, 16'h5678);

      chk("oe/we overlap cycles", overlap, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
